key_cmd_ctrl: RTL
=================

KEY_CMD_CTRL -- requirements
Module: key_cmd_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 4: consecutive stable synchronized cycles required to accept a key level change.
REQ-002 Parameter RST_HOLD, default 4: cycles cpu_reset_n is held low per CPU reset.
REQ-003 Single clock domain; CLOCK_50 is the only clock; reset_n is asynchronous and active-low.
REQ-004 CLOCK_50  in  1  system clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  asynchronous active-low block reset.
REQ-006 KEY  in  4  raw pushbuttons, active-low (0 = pressed), asynchronous to CLOCK_50.
REQ-007 halt_req  in  1  processor halt request, synchronous, level.
REQ-008 cpu_reset_n  out  1  active-low reset to processor datapath.
REQ-009 run  out  1  processor clock-enable, free-running execution.
REQ-010 step_pulse  out  1  one-cycle single-step enable.
REQ-011 key_press  out  4  one-cycle press pulse per key, after debounce.
REQ-012 state  out  2  current FSM state encoding.

Function
REQ-013 Each KEY bit passes through a 2-flop synchronizer, then a debouncer with a per-key counter.
REQ-014 Debouncer: counter clears when synchronized level equals the debounced level; otherwise increments; at DB_CYCLES-1 the debounced level takes the synchronized value and the counter clears.
REQ-015 key_press[i] is high for exactly one cycle on the debounced 1->0 transition of key i; releases produce no pulse.
REQ-016 Latency: raw KEY falling edge held stable -> key_press high exactly DB_CYCLES+2 cycles later; glitches shorter than DB_CYCLES cycles produce no pulse.
REQ-017 FSM states: RESETTING=0, IDLE=1, RUN=2, HALT=3.
REQ-018 RESETTING: cpu_reset_n=0, run=0; after RST_HOLD cycles -> IDLE.
REQ-019 key_press[3] in any state -> RESETTING with hold counter restarted, including mid-RESETTING.
REQ-020 key_press[2]: IDLE->RUN, RUN->HALT, HALT->RUN; ignored in RESETTING.
REQ-021 key_press[1] in IDLE or HALT -> step_pulse=1 the next cycle, state unchanged; ignored in RUN and RESETTING.
REQ-022 run=1 exactly while state=RUN; step_pulse never coincides with run=1.
REQ-023 Simultaneous events, same cycle: key_press[3] outranks all; in RUN, key_press[2] together with halt_req -> HALT, single transition.
REQ-024 key_press[0] is reported only; no FSM effect.

Reset
REQ-025 reset_n low: synchronizer and debounced levels=1, counters=0, key_press=0, step_pulse=0, run=0, cpu_reset_n=0, state=RESETTING.
REQ-026 After reset_n release, the FSM performs the full RST_HOLD sequence, then enters IDLE.
REQ-027 reset_n assertion mid-operation aborts any pending step or debounce in progress, with no pulses emitted.

Configuration
REQ-028 Macro KEY_CMD_AUTOSTOP_EN defined: halt_req=1 in RUN -> HALT next cycle.
REQ-029 KEY_CMD_AUTOSTOP_EN undefined: halt_req is ignored; the port remains present.

Structure
REQ-030 Package key_cmd_pkg holds the state enum, key index constants (KEY_RST=3, KEY_RUN=2, KEY_STEP=1, KEY_AUX=0) and default parameter values.
REQ-031 Sub-module key_debounce (synchronizer, debouncer and press pulse for one key) is instantiated four times.

Verification (DB_CYCLES=4, RST_HOLD=4)
REQ-032 reset_n low 3 cycles, release -> state=0 and cpu_reset_n=0 for 4 cycles, then state=1, cpu_reset_n=1.
REQ-033 KEY=4'h7 held 10 cycles -> key_press[3] at cycle 6, RESETTING for 4 cycles, then IDLE; release -> no pulse.
REQ-034 In IDLE, KEY=4'hB held 10 cycles -> run=1; second press -> state=HALT, run=0; third press -> RUN.
REQ-035 In HALT, KEY=4'hD press -> step_pulse high exactly 1 cycle; same press in RUN -> step_pulse stays 0.
REQ-036 KEY[2] low for 3 cycles, then high -> no key_press, state unchanged.
REQ-037 RUN, halt_req=1 together with key_press[2] -> HALT with macro defined; without the macro, halt_req alone leaves RUN.

Source files
------------

// File: rtl/key_cmd_pkg.sv
// Shared definitions for the pushbutton command controller: FSM state
// encoding, key roles and default timing parameters.
package key_cmd_pkg;

    typedef enum logic [1:0] {
        RESETTING = 2'd0,
        IDLE      = 2'd1,
        RUN       = 2'd2,
        HALT      = 2'd3
    } state_t;

    localparam int KEY_RST  = 3;
    localparam int KEY_RUN  = 2;
    localparam int KEY_STEP = 1;
    localparam int KEY_AUX  = 0;

    localparam int DB_CYCLES_DEF = 4;
    localparam int RST_HOLD_DEF  = 4;

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchronizer, counter debouncer and a single-cycle
// pulse on each debounced press (1->0); releases are silent.
module key_debounce
    import key_cmd_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    input  logic key_raw,
    output logic press
);

    localparam int             CW      = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

    logic          key_p0;
    logic          key_p1;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            key_p0 <= 1'b1;
            key_p1 <= 1'b1;
            level  <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            key_p0 <= key_raw;
            key_p1 <= key_p0;
            press  <= 1'b0;
            // Any return to the accepted level restarts the stability count
            if (key_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= key_p1;
                cnt   <= '0;
                press <= ~key_p1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_cmd_ctrl.sv
// Pushbutton command controller: debounced keys drive CPU reset/run/halt/step.
// Define KEY_CMD_AUTOSTOP_EN to let halt_req stop a running processor.
module key_cmd_ctrl
    import key_cmd_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int RST_HOLD  = RST_HOLD_DEF
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [3:0] KEY,
    input  logic       halt_req,
    output logic       cpu_reset_n,
    output logic       run,
    output logic       step_pulse,
    output logic [3:0] key_press,
    output logic [1:0] state
);

    localparam int            HW       = $clog2(RST_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD - 1);

    state_t        cur_state;
    state_t        next_state;
    logic [HW-1:0] hold_cnt;
    logic          hold_clr;
    logic          step_next;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_key_debounce (
            .CLOCK_50 (CLOCK_50),
            .reset_n  (reset_n),
            .key_raw  (KEY[i]),
            .press    (key_press[i])
        );
    end

`ifdef KEY_CMD_AUTOSTOP_EN
    logic stop_req;
    assign stop_req = key_press[KEY_RUN] | halt_req;
`else
    logic stop_req;
    logic unused_halt_req;
    assign stop_req        = key_press[KEY_RUN];
    assign unused_halt_req = halt_req;
`endif

    always_comb begin
        next_state = cur_state;
        hold_clr   = 1'b0;
        step_next  = 1'b0;
        if (key_press[KEY_RST]) begin
            next_state = RESETTING;
            hold_clr   = 1'b1;
        end else begin
            unique case (cur_state)
                RESETTING: if (hold_cnt == HOLD_MAX) next_state = IDLE;
                IDLE, HALT: begin
                    // A step only fires when the state stays put, so it never overlaps run
                    if (key_press[KEY_RUN]) next_state = RUN;
                    else if (key_press[KEY_STEP]) step_next = 1'b1;
                end
                RUN: if (stop_req) next_state = HALT;
                default: next_state = RESETTING;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            cur_state  <= RESETTING;
            hold_cnt   <= '0;
            step_pulse <= 1'b0;
        end else begin
            cur_state  <= next_state;
            step_pulse <= step_next;
            if (hold_clr || next_state != RESETTING) hold_cnt <= '0;
            else hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign cpu_reset_n = (cur_state != RESETTING);
    assign run         = (cur_state == RUN);
    assign state       = cur_state;

endmodule
